// File: rtl/lcd_arb_pkg.sv
// ============================================================
// lcd_arb_pkg: shared states, default widths and LCD opcodes.
// Rev 1.0
// ============================================================
`default_nettype none

package lcd_arb_pkg;

  localparam int DEF_OP_W  = 3;
  localparam int DEF_REG_W = 4;
  localparam int DEF_VAL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } arb_state_e;

  // Opcode values understood by lcd_custom_controller, shared with the CPU.
  typedef enum logic [DEF_OP_W-1:0] {
    LCD_OP_NOP        = 3'd0,
    LCD_OP_WRITE_REG  = 3'd1,
    LCD_OP_CLEAR      = 3'd2,
    LCD_OP_PRINT_HEX  = 3'd3,
    LCD_OP_PRINT_DEC  = 3'd4,
    LCD_OP_SET_CURSOR = 3'd5
  } lcd_op_e;

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ============================================================
// rr_picker: first pending index after last_grant, modulo NUM_REQ.
// Rev 1.0
// ============================================================
`default_nettype none

module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [IDX_W-1:0]   last_grant_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   grant_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    grant_o = '0;
    cand    = '0;
    // Offsets 1..NUM_REQ so the last owner is considered last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_i) + k) % NUM_REQ);
      if (!found_o && pending_i[cand]) begin
        found_o = 1'b1;
        grant_o = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_request_arbiter.sv
// ============================================================
// lcd_request_arbiter: round-robin sharing of the LCD controller port.
// Rev 1.0
// ============================================================
`default_nettype none

module lcd_request_arbiter
  import lcd_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int OP_W        = DEF_OP_W,
  parameter int REG_W       = DEF_REG_W,
  parameter int VAL_W       = DEF_VAL_W,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*OP_W-1:0]    req_opcode,
  input  logic [NUM_REQ*REG_W-1:0]   req_reg,
  input  logic [NUM_REQ*VAL_W-1:0]   req_value,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [NUM_REQ-1:0]         req_err,
  output logic                       lcd_update,
  output logic [OP_W-1:0]            lcd_opcode,
  output logic [REG_W-1:0]           lcd_reg_idx,
  output logic [VAL_W-1:0]           lcd_value,
  input  logic                       lcd_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       arb_active
);

  localparam int               IDX_W    = $clog2(NUM_REQ);
  localparam int               CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic [NUM_REQ-1:0] capture, clear, owner_oh;
  logic [OP_W-1:0]    lcd_op_q, lcd_op_d;
  logic [REG_W-1:0]   lcd_reg_q, lcd_reg_d;
  logic [VAL_W-1:0]   lcd_val_q, lcd_val_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   pick;
  logic               found;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [OP_W-1:0]    slot_op_q  [NUM_REQ];
  logic [REG_W-1:0]   slot_reg_q [NUM_REQ];
  logic [VAL_W-1:0]   slot_val_q [NUM_REQ];

  assign capture  = req_valid & ready_q;
  assign owner_oh = NUM_REQ'(1) << grant_q;
  assign pending_d = (pending_q | capture) & ~clear;
  // Built from the pre-clear pending so ready rises one cycle after done.
  assign ready_d   = ~(pending_q | capture);

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (capture[i]) begin
        slot_op_q[i]  <= req_opcode[i*OP_W +: OP_W];
        slot_reg_q[i] <= req_reg[i*REG_W +: REG_W];
        slot_val_q[i] <= req_value[i*VAL_W +: VAL_W];
      end
    end
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_picker (
    .pending_i    (pending_q),
    .last_grant_i (last_q),
    .found_o      (found),
    .grant_o      (pick)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    lcd_op_d  = lcd_op_q;
    lcd_reg_d = lcd_reg_q;
    lcd_val_d = lcd_val_q;
    done_d    = '0;
    err_d     = '0;
    clear     = '0;
    case (state_q)
      ST_IDLE: begin
        if (found && !lcd_busy) begin
          grant_d   = pick;
          lcd_op_d  = slot_op_q[pick];
          lcd_reg_d = slot_reg_q[pick];
          lcd_val_d = slot_val_q[pick];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (lcd_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          clear   = owner_oh;
          done_d  = owner_oh;
          err_d   = owner_oh;
          last_d  = grant_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!lcd_busy) begin
          clear   = owner_oh;
          done_d  = owner_oh;
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      ready_q   <= '1;
      done_q    <= '0;
      err_q     <= '0;
      lcd_op_q  <= '0;
      lcd_reg_q <= '0;
      lcd_val_q <= '0;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      lcd_op_q  <= lcd_op_d;
      lcd_reg_q <= lcd_reg_d;
      lcd_val_q <= lcd_val_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
    end
  end

  assign req_ready   = ready_q;
  assign req_done    = done_q;
  assign req_err     = err_q;
  assign lcd_update  = (state_q == ST_ISSUE);
  assign lcd_opcode  = lcd_op_q;
  assign lcd_reg_idx = lcd_reg_q;
  assign lcd_value   = lcd_val_q;
  assign grant_idx   = grant_q;
  assign arb_active  = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/lcd_request_arbiter.md
Name: lcd_request_arbiter

Overview:
- Shares the single LCD controller port (update_req / opcode / reg_idx / value / busy) between NUM_REQ requesters, e.g. the mini CPU and a status/debug monitor.
- Each requester has a one-entry holding slot with a valid/ready handshake.
- A round-robin scheduler picks one pending slot, issues a one-cycle update pulse, tracks the controller's busy handshake, and returns a done/error pulse to the owning requester.
- Sits between the requesters and lcd_custom_controller in the top level.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- OP_W, 3, opcode width
- REG_W, 4, register index width
- VAL_W, 16, value width
- ACK_TIMEOUT, 16, cycles to wait for lcd_busy to rise after an update pulse before aborting

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request strobe/hold
- req_opcode  in  NUM_REQ*OP_W  packed opcodes; requester i at [i*OP_W +: OP_W]
- req_reg  in  NUM_REQ*REG_W  packed register indices
- req_value  in  NUM_REQ*VAL_W  packed values
- req_ready  out  NUM_REQ  slot i empty, can accept
- req_done  out  NUM_REQ  one-cycle pulse: request i finished
- req_err  out  NUM_REQ  one-cycle pulse with req_done: request i timed out
- lcd_update  out  1  one-cycle update request to the controller
- lcd_opcode  out  OP_W  held payload
- lcd_reg_idx  out  REG_W  held payload
- lcd_value  out  VAL_W  held payload
- lcd_busy  in  1  controller busy
- grant_idx  out  clog2(NUM_REQ)  index of the current or last owner
- arb_active  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All slots empty, so req_ready is all ones.
  - req_done, req_err, lcd_update = 0; lcd_opcode, lcd_reg_idx, lcd_value = 0.
  - grant_idx = 0; last_grant = NUM_REQ-1, so requester 0 has first priority.
  - State = IDLE.
  - A reset mid-transaction drops every slot with no done pulse. The top level resets the controller with the same button.
- Capture:
  - At an edge where req_valid[i] & req_ready[i], the payload is latched into slot i and pending[i] is set.
  - req_ready[i] = !pending[i], registered.
  - Requesters hold valid and payload until ready is seen.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - Condition: any pending and !lcd_busy.
  - Pick the first pending index after last_grant, modulo NUM_REQ.
  - Load the lcd_* payload registers and grant_idx, then go to ISSUE.
  - If lcd_busy is high, stay in IDLE (the controller is still finishing a write not issued by the arbiter).
- ISSUE: lcd_update = 1 for exactly this one cycle; a wait counter is cleared; next state is WAIT_ACK.
- WAIT_ACK:
  - If lcd_busy: go to WAIT_DONE.
  - Else, when the counter reaches ACK_TIMEOUT-1: clear the slot, pulse req_done and req_err for the owner, set last_grant = owner, go to IDLE.
  - Otherwise increment the counter.
- WAIT_DONE: when !lcd_busy, clear the slot, pulse req_done (req_err = 0), set last_grant = owner, go to IDLE.
- Payload hold: lcd_opcode, lcd_reg_idx and lcd_value stay constant from ISSUE until the next IDLE grant. They are never changed while lcd_busy is high.
- Latency:
  - Capture at edge k, with the arbiter idle and the controller not busy.
  - lcd_update is high in the cycle after edge k+1.
  - req_done pulses the cycle after lcd_busy is first seen low in WAIT_DONE.
  - req_ready[i] rises the cycle after req_done[i].
- Simultaneous events:
  - Captures into different slots in the same cycle are both accepted.
  - A capture into a slot being arbitrated cannot happen, because ready is low.
  - All requesters pending: grants rotate strictly, so none waits more than NUM_REQ-1 transactions.
- Busy glitch: lcd_busy rising in the same cycle as lcd_update counts in WAIT_ACK only, since lcd_busy is sampled from WAIT_ACK onward.

Decomposition:
- Shared include/package lcd_arb_pkg:
  - State encodings (IDLE=0, ISSUE=1, WAIT_ACK=2, WAIT_DONE=3).
  - Default widths OP_W, REG_W, VAL_W.
  - LCD opcode constants shared with the CPU.
- Sub-module rr_picker:
  - Inputs: pending vector, last_grant.
  - Outputs: found and grant index.
  - Purely combinational; instantiated once.

Test Plan:
- Reset then single request: requester 0 sends op=3, reg=5, val=16'h00AB; the model asserts busy 2 cycles after update and holds it 10 cycles -> exactly one lcd_update pulse with the payload stable throughout; req_done[0] pulses once; req_ready[0] back to 1.
- Contention: requesters 0 and 1 assert valid in the same cycle, 3 transactions each -> grant order 0,1,0,1,0,1; every req_done matches its owner's payload.
- Timeout: the model never raises busy -> req_done[1] and req_err[1] pulse exactly ACK_TIMEOUT+1 cycles after lcd_update; the arbiter returns to IDLE and serves the next pending request.
- Busy at entry: lcd_busy held high for 20 cycles while requester 0 is pending -> no lcd_update until busy is low; then one pulse.
- Reset mid-op: rst_n low for 1 cycle during WAIT_DONE -> lcd_update = 0, all req_ready = 1, no req_done pulse, grant restarts at requester 0.
